alarm_clock_multi: RTL
======================

Name: alarm_clock_multi

Overview:
- 24-hour BCD real-time clock with ALARM_NUM independently programmable alarms.
- Adds an alarm ring/snooze state machine and up/down field adjustment.
- Keeps time running while alarms are edited.
- Sits between the debounced key front-end (single-cycle key pulses) and the seven-segment/buzzer drivers.

Parameters:
TIME_1S, 50_000_000, clock cycles per one-second tick
CNT_W, 26, width of tick prescaler (must hold TIME_1S-1)
ALARM_NUM, 4, number of alarm channels (1..16)
SEL_W, 2, width of alarm select/ID (ceil log2 ALARM_NUM, min 1)
RING_SEC, 60, ticks the ring output stays active per trigger
SNOOZE_SEC, 300, ticks spent in snooze before re-ringing
RCNT_W, 9, width of ring/snooze counter (must hold max(RING_SEC,SNOOZE_SEC)-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_mode  in  1  pulse: cycle adjust field 0->1->2->0
key_up  in  1  pulse: increment selected field
key_down  in  1  pulse: decrement selected field
set_alarm  in  1  0 = adjust edits time; 1 = adjust edits alarm[sel_alarm]
sel_alarm  in  SEL_W  alarm being edited/displayed
alarm_en  in  ALARM_NUM  per-alarm enable
key_stop  in  1  pulse: cancel ring/snooze
key_snooze  in  1  pulse: snooze an active ring
sec_l, sec_h, min_l, min_h, hour_l, hour_h  out  4 each  current time, BCD
al_min_l, al_min_h, al_hour_l, al_hour_h  out  4 each  alarm[sel_alarm], BCD, combinational mux
adjust  out  2  0 run, 1 minute field, 2 hour field
ring  out  1  buzzer enable
ring_id  out  SEL_W  index of the ringing/snoozed alarm

Behaviour:
- Reset (async, rst_n low):
  - Prescaler = 0.
  - Time = 00:00:00.
  - All alarms = 00:00.
  - adjust = 0, ring = 0, ring_id = 0, FSM = IDLE, ring counter = 0.
- Tick: prescaler counts 0..TIME_1S-1 continuously; tick is high in the cycle where count = TIME_1S-1.
- Time advance:
  - Occurs on tick when (adjust == 0) or (set_alarm == 1).
  - Time registers update on the edge ending the tick cycle.
  - Carries: sec 59->00 increments min; min 59->00 increments hour; 23:59:59 -> 00:00:00.
  - BCD digits are never out of range.
- adjust: key_mode increments it, wrapping 2->0; it is ignored values 3 never occur.
- Field edit (adjust != 0):
  - key_up / key_down change the target field by ±1 with wrap.
    - Minute: 59<->00.
    - Hour: 23<->00.
  - No carry into the neighbouring field.
  - Target is the time (set_alarm=0) or alarm[sel_alarm] (set_alarm=1).
  - Any edit of the time clears seconds to 00 in the same cycle.
  - key_up and key_down in the same cycle: no change.
  - Keys in adjust 0: ignored.
- Match:
  - Condition (registered): adjust == 0, FSM == IDLE, a time update occurred on the previous edge, seconds == 00, and hour:min equals alarm[k] with alarm_en[k] = 1.
  - Lowest k wins.
  - On the next edge: FSM -> RING, ring = 1, ring_id = k, counter = 0.
  - Net latency: ring rises 2 edges after the tick cycle.
- RING state:
  - Counter increments on each tick.
  - At RING_SEC-1: -> IDLE, ring = 0.
  - key_stop: -> IDLE.
  - key_snooze: -> SNOOZE, ring = 0, counter = 0.
  - key_stop and key_snooze together: stop wins.
- SNOOZE state:
  - Counter increments on each tick.
  - At SNOOZE_SEC-1: -> RING, same ring_id, counter = 0.
  - key_stop: -> IDLE.
  - key_snooze: ignored.
- In RING or SNOOZE:
  - New matches are ignored.
  - alarm_en[ring_id] = 0 forces IDLE on the next edge, with ring = 0.
- ring_id holds its last value in IDLE.
- Reset mid-ring: ring drops immediately (async).

Test Plan:
- Tick/rollover (TIME_1S=4): preload 23:59:58 via edits, run 2 ticks -> 00:00:00 exactly 8 cycles later; each digit is BCD-valid throughout.
- Edit wrap: adjust=1, set_alarm=0, key_down at min 00 -> 59, hour unchanged, sec = 00. Then adjust=2, key_up at hour 23 -> 00. Time frozen while adjust != 0.
- Alarm edit while running: set_alarm=1, sel_alarm=2, adjust=1, five key_up -> alarm2 = 00:05 on al_min_*; time keeps advancing during edits.
- Match priority: alarm1 = alarm3 = 00:01, both enabled; time passes 00:00:59 -> 00:01:00 -> ring = 1, ring_id = 1, two edges after the tick; ring drops after RING_SEC ticks.
- Snooze: during RING, pulse key_snooze -> ring = 0 next edge; after SNOOZE_SEC ticks ring = 1 with the same ring_id. key_stop + key_snooze in the same cycle during RING -> IDLE.
- Enable drop/reset: during SNOOZE clear alarm_en[ring_id] -> IDLE, no re-ring. Assert rst_n low during RING -> ring = 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/alarm_clock_multi.sv
// 24-hour BCD clock with ALARM_NUM programmable alarms, ring/snooze FSM and up/down field edit.
// Latency: time updates on the edge ending the tick cycle; ring rises two edges after that tick.
// Backpressure: none; key inputs are single-cycle pulses consumed in the cycle they arrive.
module alarm_clock_multi #(
  parameter int TIME_1S    = 50_000_000,
  parameter int CNT_W      = 26,
  parameter int ALARM_NUM  = 4,
  parameter int SEL_W      = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int RCNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_mode,
  input  logic                 key_up,
  input  logic                 key_down,
  input  logic                 set_alarm,
  input  logic [SEL_W-1:0]     sel_alarm,
  input  logic [ALARM_NUM-1:0] alarm_en,
  input  logic                 key_stop,
  input  logic                 key_snooze,
  output logic [3:0]           sec_l,
  output logic [3:0]           sec_h,
  output logic [3:0]           min_l,
  output logic [3:0]           min_h,
  output logic [3:0]           hour_l,
  output logic [3:0]           hour_h,
  output logic [3:0]           al_min_l,
  output logic [3:0]           al_min_h,
  output logic [3:0]           al_hour_l,
  output logic [3:0]           al_hour_h,
  output logic [1:0]           adjust,
  output logic                 ring,
  output logic [SEL_W-1:0]     ring_id
);

  localparam logic [CNT_W-1:0]  LP_CNT_MAX  = CNT_W'(TIME_1S - 1);
  localparam logic [RCNT_W-1:0] LP_RING_MAX = RCNT_W'(RING_SEC - 1);
  localparam logic [RCNT_W-1:0] LP_SNZ_MAX  = RCNT_W'(SNOOZE_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  // BCD pair increment with wrap to 00 after vmax
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)           return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD pair decrement with wrap from 00 to vmax
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00)          return vmax;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_adjust;
  logic [7:0]        r_sec, r_min, r_hour;
  logic [7:0]        r_al_min  [ALARM_NUM];
  logic [7:0]        r_al_hour [ALARM_NUM];
  logic              r_upd;
  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_ring_id, w_ring_id_nxt;
  logic [RCNT_W-1:0] r_rcnt, w_rcnt_nxt;
  logic [7:0]        w_sec_nxt, w_min_nxt, w_hour_nxt;
  logic              w_tick, w_adv, w_step, w_edit_time, w_edit_al;
  logic              w_hit, w_match;
  logic [SEL_W-1:0]  w_hit_id;

  assign w_tick      = (r_cnt == LP_CNT_MAX);
  // Time keeps running while alarms are being edited; only a time edit freezes it
  assign w_adv       = w_tick && ((r_adjust == 2'd0) || set_alarm);
  assign w_step      = (r_adjust != 2'd0) && (key_up ^ key_down);
  assign w_edit_time = w_step && !set_alarm;
  assign w_edit_al   = w_step && set_alarm;

  // One-second prescaler, free running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CNT_W'(1);
  end

  // Adjust field selector 0 -> 1 -> 2 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_adjust <= 2'd0;
    else if (key_mode) r_adjust <= (r_adjust == 2'd2) ? 2'd0 : r_adjust + 2'd1;
  end

  // Next time: a field edit clears seconds and never carries; otherwise tick with carries
  always_comb begin
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour;
    if (w_edit_time) begin
      w_sec_nxt = 8'h00;
      if (r_adjust == 2'd1) w_min_nxt  = key_up ? bcd_inc(r_min, 8'h59)  : bcd_dec(r_min, 8'h59);
      else                  w_hour_nxt = key_up ? bcd_inc(r_hour, 8'h23) : bcd_dec(r_hour, 8'h23);
    end else if (w_adv) begin
      w_sec_nxt = bcd_inc(r_sec, 8'h59);
      if (r_sec == 8'h59) begin
        w_min_nxt = bcd_inc(r_min, 8'h59);
        if (r_min == 8'h59) w_hour_nxt = bcd_inc(r_hour, 8'h23);
      end
    end
  end

  // Time registers and the "time just advanced" flag used by the matcher
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec  <= 8'h00;
      r_min  <= 8'h00;
      r_hour <= 8'h00;
      r_upd  <= 1'b0;
    end else begin
      r_sec  <= w_sec_nxt;
      r_min  <= w_min_nxt;
      r_hour <= w_hour_nxt;
      r_upd  <= w_adv;
    end
  end

  // Alarm registers: only the selected alarm is edited
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ALARM_NUM; k++) begin
        r_al_min[k]  <= 8'h00;
        r_al_hour[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < ALARM_NUM; k++) begin
        if (w_edit_al && (sel_alarm == SEL_W'(k))) begin
          if (r_adjust == 2'd1)
            r_al_min[k]  <= key_up ? bcd_inc(r_al_min[k], 8'h59)  : bcd_dec(r_al_min[k], 8'h59);
          else
            r_al_hour[k] <= key_up ? bcd_inc(r_al_hour[k], 8'h23) : bcd_dec(r_al_hour[k], 8'h23);
        end
      end
    end
  end

  // Alarm match; scanning downward lets the lowest enabled index win
  always_comb begin
    w_hit    = 1'b0;
    w_hit_id = '0;
    for (int k = ALARM_NUM - 1; k >= 0; k--) begin
      if (alarm_en[k] && (r_al_min[k] == r_min) && (r_al_hour[k] == r_hour)) begin
        w_hit    = 1'b1;
        w_hit_id = SEL_W'(k);
      end
    end
    w_match = w_hit && (r_adjust == 2'd0) && (r_state == S_IDLE) && r_upd && (r_sec == 8'h00);
  end

  // Ring FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ring_id <= '0;
      r_rcnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ring_id <= w_ring_id_nxt;
      r_rcnt    <= w_rcnt_nxt;
    end
  end

  // Ring FSM next state: disable/stop beat snooze, which beats the tick timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_ring_id_nxt = r_ring_id;
    w_rcnt_nxt    = r_rcnt;
    case (r_state)
      S_IDLE: begin
        if (w_match) begin
          w_state_nxt   = S_RING;
          w_ring_id_nxt = w_hit_id;
          w_rcnt_nxt    = '0;
        end
      end
      S_RING: begin
        if (!alarm_en[r_ring_id] || key_stop) begin
          w_state_nxt = S_IDLE;
          w_rcnt_nxt  = '0;
        end else if (key_snooze) begin
          w_state_nxt = S_SNOOZE;
          w_rcnt_nxt  = '0;
        end else if (w_tick) begin
          if (r_rcnt == LP_RING_MAX) begin
            w_state_nxt = S_IDLE;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt  = r_rcnt + RCNT_W'(1);
          end
        end
      end
      S_SNOOZE: begin
        if (!alarm_en[r_ring_id] || key_stop) begin
          w_state_nxt = S_IDLE;
          w_rcnt_nxt  = '0;
        end else if (w_tick) begin
          if (r_rcnt == LP_SNZ_MAX) begin
            w_state_nxt = S_RING;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt  = r_rcnt + RCNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  assign sec_l     = r_sec[3:0];
  assign sec_h     = r_sec[7:4];
  assign min_l     = r_min[3:0];
  assign min_h     = r_min[7:4];
  assign hour_l    = r_hour[3:0];
  assign hour_h    = r_hour[7:4];
  assign al_min_l  = r_al_min[sel_alarm][3:0];
  assign al_min_h  = r_al_min[sel_alarm][7:4];
  assign al_hour_l = r_al_hour[sel_alarm][3:0];
  assign al_hour_h = r_al_hour[sel_alarm][7:4];
  assign adjust    = r_adjust;
  assign ring      = (r_state == S_RING);
  assign ring_id   = r_ring_id;

endmodule
